// File: rtl/bus_seq_pkg.sv
// rtl/bus_seq_pkg.sv - opcode and state encodings shared by the bus sequencer
package bus_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_t;

  localparam logic [3:0] OP_LOAD = 4'b0001;
  localparam logic [3:0] OP_MOVE = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;

  function automatic logic is_alu_op(input logic [3:0] f);
    return (f == OP_ADD) || (f == OP_SUB) || (f == OP_XOR);
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - SEL_W-bit index to N-bit one-hot with enable
// Indices at or beyond N decode to all zeros rather than wrapping.
module onehot_dec #(
  parameter int SEL_W = 3,
  parameter int N     = 8
) (
  input  logic             i_en,
  input  logic [SEL_W-1:0] i_sel,
  output logic [N-1:0]     o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < N; i++) begin
      o_onehot[i] = i_en && (i_sel == SEL_W'(i));
    end
  end

endmodule

// File: rtl/bus_sequencer.sv
// rtl/bus_sequencer.sv - multi-cycle control unit for the shared-bus datapath
// One instruction per start/done handshake; at most one bus driver per cycle.
module bus_sequencer
  import bus_seq_pkg::*;
#(
  parameter int NREG  = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       func,
  input  logic [SEL_W-1:0] rx_sel,
  input  logic [SEL_W-1:0] ry_sel,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             data_out,
  output logic [NREG-1:0]  R_in,
  output logic [NREG-1:0]  R_out,
  output logic             A_in,
  output logic             G_in,
  output logic             G_out,
  output logic             AddSub,
  output logic             XOR_enable
);

  localparam logic [SEL_W:0] NREG_LIM = (SEL_W + 1)'(NREG);

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_func;
  logic [SEL_W-1:0] r_rx;
  logic [SEL_W-1:0] r_ry;

  logic             w_rx_ok;
  logic             w_ry_ok;
  logic             w_bad;
  logic             w_rin_en;
  logic             w_rout_en;
  logic [SEL_W-1:0] w_rout_sel;

  assign w_rx_ok = {1'b0, r_rx} < NREG_LIM;
  assign w_ry_ok = {1'b0, r_ry} < NREG_LIM;

  // An index only makes the instruction illegal if that operand is used.
  always_comb begin
    w_bad = 1'b1;
    if (r_func == OP_LOAD) begin
      w_bad = !w_rx_ok;
    end else if (r_func == OP_MOVE || is_alu_op(r_func)) begin
      w_bad = !(w_rx_ok && w_ry_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_func  <= '0;
      r_rx    <= '0;
      r_ry    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_func <= func;
        r_rx   <= rx_sel;
        r_ry   <= ry_sel;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_rin_en   = 1'b0;
    w_rout_en  = 1'b0;
    w_rout_sel = r_rx;
    busy       = (r_state != S_IDLE);
    done       = 1'b0;
    illegal    = 1'b0;
    data_out   = 1'b0;
    A_in       = 1'b0;
    G_in       = 1'b0;
    G_out      = 1'b0;
    AddSub     = 1'b0;
    XOR_enable = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_T1;
      end
      S_T1: begin
        if (w_bad) begin
          done    = 1'b1;
          illegal = 1'b1;
          w_next  = S_IDLE;
        end else if (r_func == OP_LOAD) begin
          data_out = 1'b1;
          w_rin_en = 1'b1;
          done     = 1'b1;
          w_next   = S_IDLE;
        end else if (r_func == OP_MOVE) begin
          w_rout_en  = 1'b1;
          w_rout_sel = r_ry;
          w_rin_en   = 1'b1;
          done       = 1'b1;
          w_next     = S_IDLE;
        end else begin
          w_rout_en = 1'b1;
          A_in      = 1'b1;
          w_next    = S_T2;
        end
      end
      S_T2: begin
        w_rout_en  = 1'b1;
        w_rout_sel = r_ry;
        G_in       = 1'b1;
        AddSub     = (r_func == OP_SUB);
        XOR_enable = (r_func == OP_XOR);
        w_next     = S_T3;
      end
      S_T3: begin
        G_out    = 1'b1;
        w_rin_en = 1'b1;
        done     = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // The reset cycle must not load a register or signal completion.
    if (reset) begin
      w_rin_en   = 1'b0;
      w_rout_en  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      illegal    = 1'b0;
      data_out   = 1'b0;
      A_in       = 1'b0;
      G_in       = 1'b0;
      G_out      = 1'b0;
      AddSub     = 1'b0;
      XOR_enable = 1'b0;
    end
  end

  onehot_dec #(.SEL_W(SEL_W), .N(NREG)) u_rin_dec (
    .i_en     (w_rin_en),
    .i_sel    (r_rx),
    .o_onehot (R_in)
  );

  onehot_dec #(.SEL_W(SEL_W), .N(NREG)) u_rout_dec (
    .i_en     (w_rout_en),
    .i_sel    (w_rout_sel),
    .o_onehot (R_out)
  );

endmodule

// File: tb/tb_bus_sequencer.sv
// tb/tb_bus_sequencer.sv - directed bench for bus_sequencer with a 3-bit datapath model
module tb_bus_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] func = 4'b0;
  logic [2:0] rx_sel = 3'd0;
  logic [2:0] ry_sel = 3'd0;
  logic       busy, done, illegal, data_out, A_in, G_in, G_out, AddSub, XOR_enable;
  logic [7:0] R_in, R_out;

  logic       start4 = 1'b0;
  logic [3:0] func4 = 4'b0;
  logic [2:0] rx4 = 3'd0;
  logic [2:0] ry4 = 3'd0;
  logic       busy4, done4, illegal4, data_out4, A_in4, G_in4, G_out4, AddSub4, XOR_enable4;
  logic [3:0] R_in4, R_out4;

  int vectors = 0;
  int miscompares = 0;

  logic [2:0] ext_data = 3'd0;
  logic [2:0] rf [8];
  logic [2:0] acc = 3'd0;
  logic [2:0] greg = 3'd0;
  logic [2:0] bus;

  always #5 clk = ~clk;

  bus_sequencer #(.NREG(8), .SEL_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .func(func), .rx_sel(rx_sel), .ry_sel(ry_sel),
    .busy(busy), .done(done), .illegal(illegal), .data_out(data_out), .R_in(R_in), .R_out(R_out),
    .A_in(A_in), .G_in(G_in), .G_out(G_out), .AddSub(AddSub), .XOR_enable(XOR_enable)
  );

  bus_sequencer #(.NREG(4), .SEL_W(3)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .func(func4), .rx_sel(rx4), .ry_sel(ry4),
    .busy(busy4), .done(done4), .illegal(illegal4), .data_out(data_out4), .R_in(R_in4), .R_out(R_out4),
    .A_in(A_in4), .G_in(G_in4), .G_out(G_out4), .AddSub(AddSub4), .XOR_enable(XOR_enable4)
  );

  // Datapath driven by the DUT enables
  always_comb begin
    bus = 3'd0;
    if (data_out) bus = ext_data;
    else if (G_out) bus = greg;
    else for (int i = 0; i < 8; i++) if (R_out[i]) bus = rf[i];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) if (R_in[i]) rf[i] <= bus;
    if (A_in) acc <= bus;
    if (G_in) greg <= XOR_enable ? (acc ^ bus) : (AddSub ? acc - bus : acc + bus);
  end

  always @(negedge clk) begin
    vectors++;
    if ((32'(data_out) + 32'(G_out) + $countones(R_out)) > 1) begin
      miscompares++;
      $display("FAIL bus_drivers: data_out=%b G_out=%b R_out=%b, required at most one", data_out, G_out, R_out);
    end
    vectors++;
    if ($countones(R_in) > 1) begin
      miscompares++;
      $display("FAIL rin_onehot: R_in=%b, required zero or one-hot", R_in);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] f, input logic [2:0] x, input logic [2:0] y);
    start = 1'b1; func = f; rx_sel = x; ry_sel = y;
    step();
    start = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] x, input logic [2:0] v);
    ext_data = v;
    issue(4'b0001, x, 3'd0);
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, illegal, data_out, A_in, G_in, G_out, R_in, R_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b done=%b R_in=%b R_out=%b, required all zero", busy, done, R_in, R_out);
    end
    start = 1'b0;
    reset = 1'b0;
    step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_load();
    ext_data = 3'b011;
    issue(4'b0001, 3'd5, 3'd0);
    vectors++;
    if ({data_out, R_in, done, illegal, R_out} !== {1'b1, 8'b0010_0000, 1'b1, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL load_t1: data_out=%b R_in=%b done=%b illegal=%b R_out=%b, required 1 00100000 1 0 00000000",
               data_out, R_in, done, illegal, R_out);
    end
    step();
    vectors++;
    if (rf[5] !== 3'b011 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL load_result: R5=%b busy=%b, required 011 0", rf[5], busy);
    end
  endtask

  task automatic test_move();
    issue(4'b0010, 3'd6, 3'd5);
    vectors++;
    if ({R_out, R_in, done, data_out, G_out} !== {8'b0010_0000, 8'b0100_0000, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL move_t1: R_out=%b R_in=%b done=%b, required 00100000 01000000 1", R_out, R_in, done);
    end
    step();
    vectors++;
    if (rf[6] !== 3'b011 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL move_result: R6=%b busy=%b, required 011 0", rf[6], busy);
    end
    issue(4'b0010, 3'd7, 3'd7);
    vectors++;
    if ({R_out, R_in, done, illegal} !== {8'h80, 8'h80, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL move_same: R_out=%b R_in=%b done=%b illegal=%b, required 10000000 10000000 1 0",
               R_out, R_in, done, illegal);
    end
    step();
  endtask

  task automatic test_alu(input string nm, input logic [3:0] f, input logic [2:0] exp_r4,
                          input logic exp_sub, input logic exp_xor);
    do_load(3'd4, 3'b101);
    issue(f, 3'd4, 3'd5);
    vectors++;
    if ({R_out, A_in, done, busy, G_in} !== {8'b0001_0000, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL %s_t1: R_out=%b A_in=%b done=%b busy=%b, required 00010000 1 0 1", nm, R_out, A_in, done, busy);
    end
    step();
    vectors++;
    if ({R_out, G_in, AddSub, XOR_enable, R_in, done} !== {8'b0010_0000, 1'b1, exp_sub, exp_xor, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL %s_t2: R_out=%b G_in=%b AddSub=%b XOR_enable=%b, required 00100000 1 %b %b",
               nm, R_out, G_in, AddSub, XOR_enable, exp_sub, exp_xor);
    end
    step();
    vectors++;
    if ({G_out, R_in, done, R_out} !== {1'b1, 8'b0001_0000, 1'b1, 8'h00}) begin
      miscompares++;
      $display("FAIL %s_t3: G_out=%b R_in=%b done=%b R_out=%b, required 1 00010000 1 00000000", nm, G_out, R_in, done, R_out);
    end
    step();
    vectors++;
    if (rf[4] !== exp_r4 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_result: R4=%b busy=%b, required %b 0", nm, rf[4], busy, exp_r4);
    end
  endtask

  task automatic test_back_to_back();
    do_load(3'd1, 3'd1);
    do_load(3'd2, 3'd2);
    start = 1'b1; func = 4'b0011; rx_sel = 3'd1; ry_sel = 3'd2;
    step();
    func = 4'b0101; rx_sel = 3'd3; ry_sel = 3'd3;
    step();
    vectors++;
    if ({R_out, XOR_enable, G_in} !== {8'b0000_0100, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_busy_start: R_out=%b XOR_enable=%b G_in=%b, required 00000100 0 1", R_out, XOR_enable, G_in);
    end
    func = 4'b0011; rx_sel = 3'd2; ry_sel = 3'd1;
    step();
    vectors++;
    if ({R_in, done} !== {8'b0000_0010, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_first_t3: R_in=%b done=%b, required 00000010 1", R_in, done);
    end
    step();
    vectors++;
    if (busy !== 1'b0 || rf[1] !== 3'd3) begin
      miscompares++;
      $display("FAIL b2b_idle: busy=%b R1=%0d, required 0 3", busy, rf[1]);
    end
    step();
    vectors++;
    if ({busy, R_out, A_in} !== {1'b1, 8'b0000_0100, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_second_t1: busy=%b R_out=%b A_in=%b, required 1 00000100 1", busy, R_out, A_in);
    end
    step();
    step();
    start = 1'b0;
    vectors++;
    if ({R_in, done} !== {8'b0000_0100, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_second_t3: R_in=%b done=%b, required 00000100 1", R_in, done);
    end
    step();
    vectors++;
    if (rf[2] !== 3'd5 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_result: R2=%0d busy=%b, required 5 0", rf[2], busy);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] ops [3];
    ops[0] = 4'b0111; ops[1] = 4'b0000; ops[2] = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      issue(ops[k], 3'd2, 3'd3);
      vectors++;
      if ({done, illegal, data_out, R_in, R_out, A_in, G_in, G_out} !== {1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 3'b000}) begin
        miscompares++;
        $display("FAIL illegal_op_%b: done=%b illegal=%b R_in=%b R_out=%b A_in=%b, required 1 1 0 0 0",
                 ops[k], done, illegal, R_in, R_out, A_in);
      end
      step();
      vectors++;
      if ({busy, done, illegal} !== 3'b000) begin
        miscompares++;
        $display("FAIL illegal_after_%b: busy=%b done=%b illegal=%b, required 000", ops[k], busy, done, illegal);
      end
    end
  endtask

  task automatic test_nreg4();
    start4 = 1'b1; func4 = 4'b0010; rx4 = 3'd6; ry4 = 3'd1;
    step();
    start4 = 1'b0;
    vectors++;
    if ({done4, illegal4, R_in4, R_out4} !== {1'b1, 1'b1, 4'b0000, 4'b0000}) begin
      miscompares++;
      $display("FAIL nreg4_move_bad: done=%b illegal=%b R_in=%b R_out=%b, required 1 1 0000 0000", done4, illegal4, R_in4, R_out4);
    end
    step();
    start4 = 1'b1; func4 = 4'b0010; rx4 = 3'd1; ry4 = 3'd2;
    step();
    start4 = 1'b0;
    vectors++;
    if ({done4, illegal4, R_in4, R_out4} !== {1'b1, 1'b0, 4'b0010, 4'b0100}) begin
      miscompares++;
      $display("FAIL nreg4_move_ok: done=%b illegal=%b R_in=%b R_out=%b, required 1 0 0010 0100", done4, illegal4, R_in4, R_out4);
    end
    step();
    start4 = 1'b1; func4 = 4'b0001; rx4 = 3'd3; ry4 = 3'd7;
    step();
    start4 = 1'b0;
    vectors++;
    if ({done4, illegal4, data_out4, R_in4} !== {1'b1, 1'b0, 1'b1, 4'b1000}) begin
      miscompares++;
      $display("FAIL nreg4_load_ry_unused: done=%b illegal=%b data_out=%b R_in=%b, required 1 0 1 1000",
               done4, illegal4, data_out4, R_in4);
    end
    step();
  endtask

  task automatic test_reset_mid();
    do_load(3'd4, 3'b101);
    issue(4'b0011, 3'd4, 3'd5);
    step();
    vectors++;
    if (G_in !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_in_t2: G_in=%b, required 1", G_in);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({done, R_in, busy, G_in, R_out} !== {1'b0, 8'h00, 1'b0, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL rmid_reset_cycle: done=%b R_in=%b busy=%b G_in=%b R_out=%b, required all zero", done, R_in, busy, G_in, R_out);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    if ({busy, done, R_in, G_out} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL rmid_after: busy=%b done=%b R_in=%b G_out=%b, required 0 0 00000000 0", busy, done, R_in, G_out);
    end
    step();
    vectors++;
    if (rf[4] !== 3'b101 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_r4: R4=%b busy=%b, required 101 0", rf[4], busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 3'd0;
    test_reset();
    test_load();
    test_move();
    test_alu("add", 4'b0011, 3'b000, 1'b0, 1'b0);
    test_alu("sub", 4'b0100, 3'b010, 1'b1, 1'b0);
    test_alu("xor", 4'b0101, 3'b110, 1'b0, 1'b1);
    test_back_to_back();
    test_illegal();
    test_nreg4();
    test_reset_mid();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
